// File: rtl/hour_bcd_counter.sv
// Two-digit BCD hour/minute-style counter with run/edit/commit modes.
// Keyed edits go to a shadow pair and are range-checked on commit; the display and all pulses are registered.
module hour_bcd_counter #(
    parameter int unsigned MAX_VAL = 23,
    parameter int unsigned MIN_VAL = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       set_mode,
    input  logic       digit_sel,
    input  logic       key_valid,
    input  logic [3:0] key_data,
    output logic [3:0] cnt_s,
    output logic [3:0] cnt_t,
    output logic       carry,
    output logic       set_err
);

    localparam int unsigned DW = 4;
    localparam int unsigned VW = 7;

    localparam logic [DW-1:0] MIN_T     = DW'(MIN_VAL / 10);
    localparam logic [DW-1:0] MIN_S     = DW'(MIN_VAL % 10);
    localparam logic [DW-1:0] MAX_T     = DW'(MAX_VAL / 10);
    localparam logic [DW-1:0] MAX_S     = DW'(MAX_VAL % 10);
    localparam logic [DW-1:0] DIGIT_MAX = DW'(9);
    localparam logic [VW-1:0] MAX_V     = VW'(MAX_VAL);
    localparam bit            MIN_IS_ZERO = (MIN_VAL == 0);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_EDIT   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic          mode_q;
    logic [DW-1:0] cnt_tt;
    logic [DW-1:0] cnt_ss;
    logic [DW-1:0] sh_t;
    logic [DW-1:0] sh_s;

    logic [DW-1:0] cnt_tt_nx;
    logic [DW-1:0] cnt_ss_nx;
    logic [DW-1:0] sh_t_nx;
    logic [DW-1:0] sh_s_nx;
    logic [DW-1:0] disp_t_nx;
    logic [DW-1:0] disp_s_nx;
    logic          carry_nx;
    logic          set_err_nx;

    logic [VW-1:0] cnt_val;
    logic [VW-1:0] sh_val;
    logic          at_max;
    logic          sh_in_range;
    logic          key_ok;

    function automatic logic [VW-1:0] bcd_value(input logic [DW-1:0] t, input logic [DW-1:0] s);
        return VW'(t) * VW'(10) + VW'(s);
    endfunction

    // MIN_VAL is restricted to 0 or 1, so the lower bound reduces to a non-zero test.
    function automatic logic in_range(input logic [VW-1:0] v);
        return (MIN_IS_ZERO || (v != '0)) && (v <= MAX_V);
    endfunction

    assign cnt_val     = bcd_value(cnt_tt, cnt_ss);
    assign sh_val      = bcd_value(sh_t, sh_s);
    assign at_max      = (cnt_tt == MAX_T) && (cnt_ss == MAX_S);
    assign sh_in_range = in_range(sh_val);
    assign key_ok      = (key_data <= DIGIT_MAX);

    // Mode is sampled through mode_q so the FSM only sees a registered request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_RUN;
            mode_q <= 1'b0;
        end else begin
            state  <= state_nx;
            mode_q <= set_mode;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_RUN:    if (mode_q)  state_nx = ST_EDIT;
            ST_EDIT:   if (!mode_q) state_nx = ST_COMMIT;
            ST_COMMIT: state_nx = ST_RUN;
            default:   state_nx = ST_RUN;
        endcase
    end

    always_comb begin
        cnt_tt_nx  = cnt_tt;
        cnt_ss_nx  = cnt_ss;
        sh_t_nx    = sh_t;
        sh_s_nx    = sh_s;
        carry_nx   = 1'b0;
        set_err_nx = 1'b0;
        disp_t_nx  = (state == ST_EDIT) ? sh_t : cnt_tt;
        disp_s_nx  = (state == ST_EDIT) ? sh_s : cnt_ss;

        case (state)
            ST_RUN: begin
                if (tick) begin
                    if (at_max) begin
                        cnt_tt_nx = MIN_T;
                        cnt_ss_nx = MIN_S;
                        carry_nx  = 1'b1;
                    end else if (cnt_ss == DIGIT_MAX) begin
                        cnt_ss_nx = '0;
                        cnt_tt_nx = cnt_tt + DW'(1);
                    end else begin
                        cnt_ss_nx = cnt_ss + DW'(1);
                    end
                end
                // Shadow captures the count as it stood before this edge.
                if (state_nx == ST_EDIT) begin
                    sh_t_nx = cnt_tt;
                    sh_s_nx = cnt_ss;
                end
            end
            ST_EDIT: begin
                if (key_valid && key_ok) begin
                    if (digit_sel) sh_t_nx = key_data;
                    else           sh_s_nx = key_data;
                end
            end
            ST_COMMIT: begin
                if (sh_in_range) begin
                    cnt_tt_nx = sh_t;
                    cnt_ss_nx = sh_s;
                end else begin
                    cnt_tt_nx  = MIN_T;
                    cnt_ss_nx  = MIN_S;
                    set_err_nx = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_tt  <= MIN_T;
            cnt_ss  <= MIN_S;
            sh_t    <= MIN_T;
            sh_s    <= MIN_S;
            cnt_t   <= MIN_T;
            cnt_s   <= MIN_S;
            carry   <= 1'b0;
            set_err <= 1'b0;
        end else begin
            cnt_tt  <= cnt_tt_nx;
            cnt_ss  <= cnt_ss_nx;
            sh_t    <= sh_t_nx;
            sh_s    <= sh_s_nx;
            cnt_t   <= disp_t_nx;
            cnt_s   <= disp_s_nx;
            carry   <= carry_nx;
            set_err <= set_err_nx;
        end
    end

    // The live count must always be two BCD digits inside the legal window.
    count_legal_a: assert property (@(posedge clk) disable iff (rst)
        (cnt_ss <= DIGIT_MAX) && (cnt_tt <= DIGIT_MAX) && in_range(cnt_val));

endmodule

// File: tb/tb_hour_bcd_counter.sv
// Bench for hour_bcd_counter: default and 1..12 instances share stimulus,
// a value-level model feeds per-instance expectation queues drained by a monitor.
module tb_hour_bcd_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       set_mode;
    logic       digit_sel;
    logic       key_valid;
    logic [3:0] key_data;

    logic [3:0] cnt_s0, cnt_t0, cnt_s1, cnt_t1;
    logic       carry0, set_err0, carry1, set_err1;

    always #5 clk = ~clk;

    hour_bcd_counter dut0 (
        .clk(clk), .rst(rst), .tick(tick), .set_mode(set_mode), .digit_sel(digit_sel),
        .key_valid(key_valid), .key_data(key_data),
        .cnt_s(cnt_s0), .cnt_t(cnt_t0), .carry(carry0), .set_err(set_err0)
    );

    hour_bcd_counter #(.MAX_VAL(12), .MIN_VAL(1)) dut1 (
        .clk(clk), .rst(rst), .tick(tick), .set_mode(set_mode), .digit_sel(digit_sel),
        .key_valid(key_valid), .key_data(key_data),
        .cnt_s(cnt_s1), .cnt_t(cnt_t1), .carry(carry1), .set_err(set_err1)
    );

    typedef struct {
        int disp;
        int carry;
        int err;
    } exp_t;

    localparam int PH_RUN    = 0;
    localparam int PH_EDIT   = 1;
    localparam int PH_COMMIT = 2;

    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   nc0 = 0, nc1 = 0, ne0 = 0, ne1 = 0;

    int m_max[2] = '{23, 12};
    int m_min[2] = '{0, 1};
    int m_cnt[2];
    int m_sht[2];
    int m_shs[2];
    int m_phase[2];
    int m_modeq[2];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int disp0();
        return int'(cnt_t0) * 10 + int'(cnt_s0);
    endfunction

    function automatic int disp1();
        return int'(cnt_t1) * 10 + int'(cnt_s1);
    endfunction

    // Value-level model: counts as integers, digits only for the shadow entry.
    task automatic model_step(input int i, output exp_t e);
        int old_cnt;
        int v;
        e.carry = 0;
        e.err   = 0;
        if (rst) begin
            m_cnt[i]   = m_min[i];
            m_sht[i]   = m_min[i] / 10;
            m_shs[i]   = m_min[i] % 10;
            m_phase[i] = PH_RUN;
            m_modeq[i] = 0;
            e.disp     = m_min[i];
            return;
        end
        e.disp  = (m_phase[i] == PH_EDIT) ? m_sht[i] * 10 + m_shs[i] : m_cnt[i];
        old_cnt = m_cnt[i];
        case (m_phase[i])
            PH_RUN: begin
                if (tick) begin
                    if (m_cnt[i] == m_max[i]) begin
                        m_cnt[i] = m_min[i];
                        e.carry  = 1;
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end
                if (m_modeq[i] != 0) begin
                    m_sht[i]   = old_cnt / 10;
                    m_shs[i]   = old_cnt % 10;
                    m_phase[i] = PH_EDIT;
                end
            end
            PH_EDIT: begin
                if (key_valid && int'(key_data) <= 9) begin
                    if (digit_sel) m_sht[i] = int'(key_data);
                    else           m_shs[i] = int'(key_data);
                end
                if (m_modeq[i] == 0) m_phase[i] = PH_COMMIT;
            end
            default: begin
                v = m_sht[i] * 10 + m_shs[i];
                if (v >= m_min[i] && v <= m_max[i]) begin
                    m_cnt[i] = v;
                end else begin
                    m_cnt[i] = m_min[i];
                    e.err    = 1;
                end
                m_phase[i] = PH_RUN;
            end
        endcase
        m_modeq[i] = int'(set_mode);
    endtask

    always @(posedge clk) begin
        exp_t e;
        model_step(0, e);
        q0.push_back(e);
        model_step(1, e);
        q1.push_back(e);
    end

    // Monitor: every settled cycle the DUT outputs are held against the queued prediction.
    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check("d0_tens",  int'(cnt_t0),   e.disp / 10);
            check("d0_units", int'(cnt_s0),   e.disp % 10);
            check("d0_carry", int'(carry0),   e.carry);
            check("d0_err",   int'(set_err0), e.err);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check("d1_tens",  int'(cnt_t1),   e.disp / 10);
            check("d1_units", int'(cnt_s1),   e.disp % 10);
            check("d1_carry", int'(carry1),   e.carry);
            check("d1_err",   int'(set_err1), e.err);
        end
    end

    always @(posedge clk) begin
        #1;
        if (carry0)   nc0++;
        if (carry1)   nc1++;
        if (set_err0) ne0++;
        if (set_err1) ne1++;
    end

    task automatic drive(input logic r, input logic t, input logic sm, input logic ds,
                         input logic kv, input logic [3:0] kd);
        rst       = r;
        tick      = t;
        set_mode  = sm;
        digit_sel = ds;
        key_valid = kv;
        key_data  = kd;
        @(negedge clk);
    endtask

    task automatic edit_entry(input logic [3:0] tens, input logic [3:0] units);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, tens);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, units);
    endtask

    task automatic commit_idle();
        repeat (4) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int snap_c0, snap_e0, snap_e1;
        logic sm;
        rst = 1'b1; tick = 1'b0; set_mode = 1'b0; digit_sel = 1'b0; key_valid = 1'b0; key_data = 4'd0;
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd7);
        check("rst_disp0", disp0(), 0);
        check("rst_disp1", disp1(), 1);

        // 23 ticks; the 1..12 instance wraps on the 12th.
        repeat (11) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        check("wrap_carry1", int'(carry1), 1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        check("wrap_disp1", disp1(), 1);
        repeat (10) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        check("disp23", disp0(), 23);
        check("no_carry_23", nc0, 0);

        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        check("carry_at_wrap", int'(carry0), 1);
        check("disp_lags_wrap", disp0(), 23);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        check("disp_wrap0", disp0(), 0);
        check("carry_once", nc0, 1);

        repeat (10) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        check("disp09_to_10", disp0(), 10);

        // Edit to 21 with an ignored out-of-range key and ticks during edit.
        snap_c0 = nc0; snap_e0 = ne0;
        edit_entry(4'd2, 4'd1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd12);
        check("edit_shadow21", disp0(), 21);
        commit_idle();
        check("commit21", disp0(), 21);
        check("no_err21", ne0 - snap_e0, 0);
        check("no_carry_edit", nc0 - snap_c0, 0);

        snap_e0 = ne0;
        edit_entry(4'd2, 4'd5);
        commit_idle();
        check("err25_pulse", ne0 - snap_e0, 1);
        check("err25_disp", disp0(), 0);

        snap_e0 = ne0; snap_e1 = ne1;
        edit_entry(4'd0, 4'd0);
        commit_idle();
        check("err00_pulse1", ne1 - snap_e1, 1);
        check("err00_disp1", disp1(), 1);
        check("ok00_noerr0", ne0 - snap_e0, 0);
        check("ok00_disp0", disp0(), 0);

        // Reset in the middle of an edit holding 15.
        snap_e0 = ne0;
        edit_entry(4'd1, 4'd5);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        check("rst_edit_disp", disp0(), 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        check("tick_after_rst", disp0(), 1);
        check("rst_edit_noerr", ne0 - snap_e0, 0);

        // set_mode 1,0,1 back-to-back, then held in edit.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        repeat (4) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd8);
        commit_idle();

        sm = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 7) == 0) sm = ~sm;
            drive(($urandom_range(0, 63) == 0), 1'($urandom), sm, 1'($urandom),
                  1'($urandom), 4'($urandom_range(0, 15)));
        end
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hour_bcd_counter.md
HOUR_BCD_COUNTER -- requirements
Module: hour_bcd_counter

Interface
REQ-001 The parameters SHALL be:
- MAX_VAL, default 23: terminal count, legal range 1..99.
- MIN_VAL, default 0: wrap/reset value, 0 or 1, and less than MAX_VAL.
REQ-002 The ports SHALL be:
- clk, input, 1: single clock; all logic on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- tick, input, 1: one-cycle count-enable pulse.
- set_mode, input, 1: 1 = edit mode, 0 = run mode.
- digit_sel, input, 1: 0 = edit units digit, 1 = edit tens digit.
- key_valid, input, 1: key-entry strobe.
- key_data, input, 4: BCD digit being entered.
- cnt_s, output, 4: registered BCD units digit.
- cnt_t, output, 4: registered BCD tens digit.
- carry, output, 1: one-cycle wrap pulse.
- set_err, output, 1: one-cycle invalid-commit pulse.
REQ-003 The block SHALL use one clock, clk; reset rst SHALL be synchronous and active-high.

Function
REQ-004 Internal state SHALL be:
- count pair (cnt_tt, cnt_ss);
- shadow pair (sh_t, sh_s);
- mode register mode_q, which is set_mode delayed one cycle.
REQ-005 The FSM SHALL have states RUN, EDIT and COMMIT:
- RUN -> EDIT when set_mode=1;
- EDIT -> COMMIT when set_mode=0;
- COMMIT -> RUN unconditionally after one cycle.
REQ-006 On RUN->EDIT, the shadow pair SHALL load the current count pair in the same edge.
REQ-007 In RUN with tick=1 and count != MAX_VAL, the count SHALL increment in BCD: units 9 -> 0 with tens +1, otherwise units +1.
REQ-008 In RUN with tick=1 and count == MAX_VAL, the count SHALL load MIN_VAL (tens = MIN_VAL/10, units = MIN_VAL%10), and carry SHALL be 1 for exactly that one cycle.
REQ-009 carry SHALL be 0 in all other cycles, including every cycle in EDIT and COMMIT.
REQ-010 In RUN with tick=0, the count SHALL hold.
REQ-011 In EDIT, tick SHALL be ignored: no count change and no carry.
REQ-012 In EDIT, key_valid=1 with key_data <= 9 SHALL write key_data to sh_s when digit_sel=0, and to sh_t when digit_sel=1.
REQ-013 In EDIT, key_valid=1 with key_data > 9 SHALL be ignored and the shadow pair SHALL hold.
REQ-014 In COMMIT, if the value 10*sh_t + sh_s lies in [MIN_VAL, MAX_VAL], the count SHALL load the shadow pair.
REQ-015 In COMMIT, if the value lies outside [MIN_VAL, MAX_VAL], the count SHALL load MIN_VAL and set_err SHALL be 1 for that one cycle.
REQ-016 A tick arriving in the COMMIT cycle SHALL be ignored.
REQ-017 cnt_t/cnt_s SHALL register the shadow pair while in EDIT and the count pair otherwise, with one cycle latency after the internal register update.
REQ-018 Consequently, carry SHALL lead the displayed wrap value by exactly one cycle.
REQ-019 The count pair SHALL never hold a non-BCD digit or a value outside [MIN_VAL, MAX_VAL]; this SHALL be checkable by assertion.
REQ-020 If set_mode toggles 1 -> 0 -> 1 on consecutive cycles, the block SHALL pass through COMMIT and then re-enter EDIT, reloading the shadow pair from the just-committed count.

Reset
REQ-021 While rst=1, regardless of the other inputs:
- state SHALL be RUN;
- count, shadow and cnt_t/cnt_s SHALL equal MIN_VAL in BCD;
- carry and set_err SHALL be 0;
- mode_q SHALL be 0.
REQ-022 A rst asserted during EDIT SHALL discard the shadow pair, with no commit and no set_err pulse.
REQ-023 On the first cycle after rst deasserts, the block SHALL respond to tick normally.

Verification
REQ-024 Default parameters:
- Stimulus: reset, then 23 ticks.
- Required response: cnt_t/cnt_s = 2/3 and carry never asserted.
- Stimulus: one further tick.
- Required response: count = 00, carry pulses 1 cycle, and display shows 0/0 on the next cycle.
REQ-025 Default parameters:
- Stimulus: count = 09, one tick.
- Required response: display shows 1/0 (tens/units).
REQ-026 Default parameters:
- Stimulus: set_mode=1; key 2 on digit_sel=1; key 1 on digit_sel=0; key 12 (ignored); set_mode=0.
- Required response: count = 21 after COMMIT, and set_err stays 0.
REQ-027 Default parameters:
- Stimulus: edit entry 2/5, then commit.
- Required response: set_err pulses once and count = 00.
- Stimulus: ticks applied during EDIT.
- Required response: count unchanged and carry stays 0.
REQ-028 Parameters MAX_VAL=12, MIN_VAL=1:
- Stimulus: reset.
- Required response: display 0/1.
- Stimulus: ticks from 12.
- Required response: count wraps to 01 with a carry pulse.
- Stimulus: edit entry 0/0, then commit.
- Required response: set_err pulses and count = 01.
REQ-029 Default parameters:
- Stimulus: assert rst mid-EDIT with shadow = 15.
- Required response: count = 00, no set_err pulse, and state = RUN on the cycle after rst deasserts.
